// File: rtl/memory_ctrl_if.sv
// Memory-stage handshake: pipeline request/result plus the data-bus request/response.
// The master side is the controller; the slave side is the pipeline/bus environment.
interface memory_ctrl_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            is_load;
  logic            is_store;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [1:0]      msize;
  logic            ld_unsigned;
  logic            stall;
  logic            out_valid;
  logic [XLEN-1:0] rdata;
  logic            misalign;
  logic            dreq_valid;
  logic [XLEN-1:0] dreq_addr;
  logic [2:0]      dreq_size;
  logic [7:0]      dreq_strobe;
  logic [XLEN-1:0] dreq_data;
  logic            dresp_addr_ok;
  logic            dresp_data_ok;
  logic [XLEN-1:0] dresp_data;

  modport master (
    input  in_valid, is_load, is_store, addr, wdata, msize, ld_unsigned,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output stall, out_valid, rdata, misalign,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );

  modport slave (
    output in_valid, is_load, is_store, addr, wdata, msize, ld_unsigned,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  stall, out_valid, rdata, misalign,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );
endinterface

// File: rtl/memory_ctrl.sv
// Memory-stage controller: one outstanding bus access at a time, split address/data
// handshake, byte-lane alignment of store data and extension of load results.
module memory_ctrl #(
  parameter int XLEN = 64
) (
  input logic            clk,
  input logic            reset,
  memory_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_e;

  state_e          state_q;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      msize_q;
  logic            store_q;
  logic            uns_q;
  logic            dreq_valid_q;
  logic [7:0]      strobe_q;
  logic [XLEN-1:0] sdata_q;
  logic [XLEN-1:0] rdata_q;

  logic       mem_op;
  logic       mis;
  logic [2:0] amask;
  logic [8:0] bmask;
  logic [7:0] strobe_d;
  logic [XLEN-1:0] sdata_d;
  logic [XLEN-1:0] ld_d;

  function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [63:0] sh;
    sh = raw >> {off, 3'b000};
    case (sz)
      2'd0:    load_ext = uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    load_ext = uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    load_ext = uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: load_ext = sh;
    endcase
  endfunction

  assign mem_op   = bus.is_load | bus.is_store;
  assign amask    = 3'((4'd1 << bus.msize) - 4'd1);
  assign mis      = |(bus.addr[2:0] & amask);
  assign bmask    = (9'd1 << (4'd1 << bus.msize)) - 9'd1;
  assign strobe_d = bus.is_store ? (bmask[7:0] << bus.addr[2:0]) : 8'h00;
  assign sdata_d  = bus.is_store ? (bus.wdata << {bus.addr[2:0], 3'b000}) : '0;
  assign ld_d     = load_ext(bus.dresp_data, addr_q[2:0], msize_q, uns_q);

  // Non-memory and misaligned results retire combinationally from IDLE.
  always_comb begin
    bus.stall     = 1'b0;
    bus.out_valid = 1'b0;
    bus.misalign  = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        if (!mem_op) bus.out_valid = 1'b1;
        else if (mis) begin
          bus.out_valid = 1'b1;
          bus.misalign  = 1'b1;
        end else bus.stall = 1'b1;
      end
      REQ, DATA: bus.stall     = 1'b1;
      DONE:      bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      msize_q      <= '0;
      store_q      <= 1'b0;
      uns_q        <= 1'b0;
      dreq_valid_q <= 1'b0;
      strobe_q     <= '0;
      sdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid && mem_op && !mis) begin
          addr_q       <= bus.addr;
          msize_q      <= bus.msize;
          store_q      <= bus.is_store;
          uns_q        <= bus.ld_unsigned;
          strobe_q     <= strobe_d;
          sdata_q      <= sdata_d;
          dreq_valid_q <= 1'b1;
          state_q      <= REQ;
        end
        // data_ok only counts once the address phase has been accepted.
        REQ: if (bus.dresp_addr_ok) begin
          dreq_valid_q <= 1'b0;
          if (bus.dresp_data_ok) begin
            if (!store_q) rdata_q <= ld_d;
            state_q <= DONE;
          end else begin
            state_q <= DATA;
          end
        end
        DATA: if (bus.dresp_data_ok) begin
          if (!store_q) rdata_q <= ld_d;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stores report zero in DONE without disturbing the last load value.
  assign bus.rdata       = (state_q == DONE && store_q) ? '0 : rdata_q;
  assign bus.dreq_valid  = dreq_valid_q;
  assign bus.dreq_addr   = addr_q;
  assign bus.dreq_size   = {1'b0, msize_q};
  assign bus.dreq_strobe = strobe_q;
  assign bus.dreq_data   = sdata_q;

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench for memory_ctrl: hand-computed vectors for pass-through, loads,
// stores, misalignment, bus wait states and reset mid-transaction.
module tb_memory_ctrl;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  memory_ctrl_if #(.XLEN(64)) bus_if ();

  memory_ctrl #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [63:0] a,
                       input logic [63:0] wd, input logic [1:0] sz, input logic uns);
    bus_if.in_valid    = 1'b1;
    bus_if.is_load     = ld;
    bus_if.is_store    = st;
    bus_if.addr        = a;
    bus_if.wdata       = wd;
    bus_if.msize       = sz;
    bus_if.ld_unsigned = uns;
  endtask

  task automatic quiet();
    bus_if.in_valid = 1'b0;
    bus_if.is_load  = 1'b0;
    bus_if.is_store = 1'b0;
  endtask

  // Aligned load completing with addr_ok and data_ok together on the first REQ cycle.
  task automatic do_load(input string tag, input logic [63:0] a, input logic [1:0] sz,
                         input logic uns, input logic [63:0] resp, input logic [63:0] exp);
    issue(1'b1, 1'b0, a, 64'h0, sz, uns);
    cyc();
    quiet();
    bus_if.dresp_addr_ok = 1'b1;
    bus_if.dresp_data_ok = 1'b1;
    bus_if.dresp_data    = resp;
    @(negedge clk);
    chk({tag, "_req_valid"}, 64'(bus_if.dreq_valid), 64'd1);
    chk({tag, "_req_strobe"}, 64'(bus_if.dreq_strobe), 64'h0);
    cyc();
    bus_if.dresp_addr_ok = 1'b0;
    bus_if.dresp_data_ok = 1'b0;
    @(negedge clk);
    chk({tag, "_out_valid"}, 64'(bus_if.out_valid), 64'd1);
    chk({tag, "_rdata"}, bus_if.rdata, exp);
    cyc();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus_if.in_valid      = 1'b0;
    bus_if.is_load       = 1'b0;
    bus_if.is_store      = 1'b0;
    bus_if.addr          = '0;
    bus_if.wdata         = '0;
    bus_if.msize         = '0;
    bus_if.ld_unsigned   = 1'b0;
    bus_if.dresp_addr_ok = 1'b0;
    bus_if.dresp_data_ok = 1'b0;
    bus_if.dresp_data    = '0;
    cyc();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", 64'(bus_if.stall), 64'd0);
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    chk("rst_misalign", 64'(bus_if.misalign), 64'd0);
    chk("rst_rdata", bus_if.rdata, 64'h0);
    chk("rst_dreq_addr", bus_if.dreq_addr, 64'h0);
    cyc();

    // Non-memory instruction retires the same cycle.
    issue(1'b0, 1'b0, 64'h1234, 64'h0, 2'd0, 1'b0);
    @(negedge clk);
    chk("nonmem_out_valid", 64'(bus_if.out_valid), 64'd1);
    chk("nonmem_stall", 64'(bus_if.stall), 64'd0);
    chk("nonmem_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    cyc();

    // lb 0x1003, signed, single-cycle bus response.
    issue(1'b1, 1'b0, 64'h1003, 64'h0, 2'd0, 1'b0);
    @(negedge clk);
    chk("lb_cap_stall", 64'(bus_if.stall), 64'd1);
    chk("lb_cap_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("lb_cap_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    cyc();
    quiet();
    bus_if.dresp_addr_ok = 1'b1;
    bus_if.dresp_data_ok = 1'b1;
    bus_if.dresp_data    = 64'h00000000_80000000;
    @(negedge clk);
    chk("lb_req_valid", 64'(bus_if.dreq_valid), 64'd1);
    chk("lb_req_addr", bus_if.dreq_addr, 64'h1003);
    chk("lb_req_size", 64'(bus_if.dreq_size), 64'd0);
    chk("lb_req_strobe", 64'(bus_if.dreq_strobe), 64'h0);
    chk("lb_req_data", bus_if.dreq_data, 64'h0);
    chk("lb_req_stall", 64'(bus_if.stall), 64'd1);
    cyc();
    bus_if.dresp_addr_ok = 1'b0;
    bus_if.dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("lb_done_out_valid", 64'(bus_if.out_valid), 64'd1);
    chk("lb_done_stall", 64'(bus_if.stall), 64'd0);
    chk("lb_done_rdata", bus_if.rdata, 64'hFFFFFFFF_FFFFFF80);
    chk("lb_done_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    cyc();

    // sh 0x2006 with address wait states, then a data wait state.
    issue(1'b0, 1'b1, 64'h2006, 64'hBEEF, 2'd1, 1'b0);
    cyc();
    quiet();
    bus_if.wdata = 64'h1234_5678;
    bus_if.addr  = 64'h0;
    for (int i = 0; i < 3; i++) begin
      bus_if.dresp_data_ok = (i == 1);
      @(negedge clk);
      chk("sh_wait_valid", 64'(bus_if.dreq_valid), 64'd1);
      chk("sh_wait_strobe", 64'(bus_if.dreq_strobe), 64'hC0);
      chk("sh_wait_data", bus_if.dreq_data, 64'hBEEF0000_00000000);
      chk("sh_wait_addr", bus_if.dreq_addr, 64'h2006);
      chk("sh_wait_stall", 64'(bus_if.stall), 64'd1);
      chk("sh_wait_out_valid", 64'(bus_if.out_valid), 64'd0);
      cyc();
    end
    bus_if.dresp_data_ok = 1'b0;
    bus_if.dresp_addr_ok = 1'b1;
    @(negedge clk);
    chk("sh_aok_valid", 64'(bus_if.dreq_valid), 64'd1);
    chk("sh_aok_size", 64'(bus_if.dreq_size), 64'd1);
    cyc();
    bus_if.dresp_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("sh_data_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
      chk("sh_data_stall", 64'(bus_if.stall), 64'd1);
      chk("sh_data_out_valid", 64'(bus_if.out_valid), 64'd0);
      cyc();
    end
    bus_if.dresp_data_ok = 1'b1;
    cyc();
    bus_if.dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("sh_done_out_valid", 64'(bus_if.out_valid), 64'd1);
    chk("sh_done_stall", 64'(bus_if.stall), 64'd0);
    chk("sh_done_rdata", bus_if.rdata, 64'h0);
    cyc();
    @(negedge clk);
    chk("sh_after_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rdata_hold", bus_if.rdata, 64'hFFFFFFFF_FFFFFF80);
    cyc();

    // lw 0x1002 is misaligned and never reaches the bus.
    issue(1'b1, 1'b0, 64'h1002, 64'h0, 2'd2, 1'b0);
    @(negedge clk);
    chk("lw_mis_misalign", 64'(bus_if.misalign), 64'd1);
    chk("lw_mis_out_valid", 64'(bus_if.out_valid), 64'd1);
    chk("lw_mis_stall", 64'(bus_if.stall), 64'd0);
    chk("lw_mis_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    cyc();
    quiet();
    @(negedge clk);
    chk("lw_mis_next_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    chk("lw_mis_next_stall", 64'(bus_if.stall), 64'd0);
    cyc();

    // sw 0x4: upper word lanes.
    issue(1'b0, 1'b1, 64'h4, 64'hDEADBEEF, 2'd2, 1'b0);
    cyc();
    quiet();
    bus_if.dresp_addr_ok = 1'b1;
    bus_if.dresp_data_ok = 1'b1;
    @(negedge clk);
    chk("sw_strobe", 64'(bus_if.dreq_strobe), 64'hF0);
    chk("sw_data", bus_if.dreq_data, 64'hDEADBEEF_00000000);
    cyc();
    bus_if.dresp_addr_ok = 1'b0;
    bus_if.dresp_data_ok = 1'b0;
    cyc();

    // ld 0x3000 unsigned through the DATA state.
    issue(1'b1, 1'b0, 64'h3000, 64'h0, 2'd3, 1'b1);
    cyc();
    quiet();
    bus_if.dresp_addr_ok = 1'b1;
    @(negedge clk);
    chk("ld_req_size", 64'(bus_if.dreq_size), 64'd3);
    cyc();
    bus_if.dresp_addr_ok = 1'b0;
    bus_if.dresp_data_ok = 1'b1;
    bus_if.dresp_data    = 64'h81234567_89ABCDEF;
    cyc();
    bus_if.dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("ld_out_valid", 64'(bus_if.out_valid), 64'd1);
    chk("ld_rdata", bus_if.rdata, 64'h81234567_89ABCDEF);
    cyc();

    do_load("lhu", 64'h4002, 2'd1, 1'b1, 64'h00000000_80010000, 64'h00000000_00008001);
    do_load("lh",  64'h4002, 2'd1, 1'b0, 64'h00000000_80010000, 64'hFFFFFFFF_FFFF8001);
    do_load("lw",  64'h4004, 2'd2, 1'b0, 64'hF2345678_00000000, 64'hFFFFFFFF_F2345678);
    do_load("lbu", 64'h4007, 2'd0, 1'b1, 64'hA5000000_00000000, 64'h00000000_000000A5);

    // Reset while waiting for data abandons the access; a late data_ok is ignored.
    issue(1'b1, 1'b0, 64'h10, 64'h0, 2'd0, 1'b0);
    cyc();
    quiet();
    bus_if.dresp_addr_ok = 1'b1;
    cyc();
    bus_if.dresp_addr_ok = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus_if.dresp_data_ok = 1'b1;
    bus_if.dresp_data    = 64'hFF;
    @(negedge clk);
    chk("rstdata_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    chk("rstdata_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rstdata_stall", 64'(bus_if.stall), 64'd0);
    chk("rstdata_rdata", bus_if.rdata, 64'h0);
    cyc();
    bus_if.dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("rstdata_late_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rstdata_late_rdata", bus_if.rdata, 64'h0);
    chk("rstdata_late_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
